// File: rtl/bus_arbiter_7800_if.sv
// Request/grant/halt handshake bundle between the 7800 bus arbiter and its requesters.
// The arbiter uses the master modport; requesters and the CPU wrapper use the slave side.
interface bus_arbiter_7800_if;
  logic       clr_req;
  logic       clr_grant;
  logic       dma_req;
  logic       dma_done;
  logic       dma_grant;
  logic       cpu_halt_b;
  logic       cpu_halted;
  logic       cpu_grant;
  logic [1:0] owner;
  logic       halt_err;

  modport master (
    input  clr_req, dma_req, dma_done, cpu_halted,
    output clr_grant, dma_grant, cpu_halt_b, cpu_grant, owner, halt_err
  );

  modport slave (
    output clr_req, dma_req, dma_done, cpu_halted,
    input  clr_grant, dma_grant, cpu_halt_b, cpu_grant, owner, halt_err
  );
endinterface

// File: rtl/bus_arbiter_7800.sv
// 7800 system bus arbiter: CPU default owner, MARIA DMA via halt handshake, memory-clear engine.
// Optional ARB_STATS_EN adds frame_start/dma_slots per-frame DMA slot accounting.
module bus_arbiter_7800 #(
  parameter int unsigned HALT_TIMEOUT = 7,
  parameter int unsigned DMA_MAX      = 1023,
  parameter int unsigned CNT_W        = 10
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     pclk0,
`ifdef ARB_STATS_EN
  input  logic                     frame_start,
  output logic [15:0]              dma_slots,
`endif
  bus_arbiter_7800_if.master       bus
);

  localparam int unsigned TO_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT + 1);

  localparam logic [1:0] OWN_CPU = 2'b00;
  localparam logic [1:0] OWN_DMA = 2'b01;
  localparam logic [1:0] OWN_CLR = 2'b10;
  localparam logic [1:0] OWN_TRN = 2'b11;

  typedef enum logic [2:0] {
    ST_CPU_OWN,
    ST_HALT_REQ,
    ST_DMA_OWN,
    ST_RELEASE,
    ST_CLR_OWN
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d, to_inc;
  logic [CNT_W-1:0]  wd_q, wd_d, wd_inc;
  logic              wd_expire;
  logic              halt_err_q, halt_err_d;
  logic              cpu_grant_q, cpu_grant_d;
  logic              dma_grant_q, dma_grant_d;
  logic              clr_grant_q, clr_grant_d;
  logic              cpu_halt_b_q, cpu_halt_b_d;
  logic [1:0]        owner_q, owner_d;

  // Saturating increments; the watchdog expires when it reaches DMA_MAX
  assign to_inc    = (to_q == {TO_W{1'b1}}) ? to_q : to_q + TO_W'(1);
  assign wd_inc    = (wd_q == {CNT_W{1'b1}}) ? wd_q : wd_q + CNT_W'(1);
  assign wd_expire = (wd_inc == CNT_W'(DMA_MAX));

  // Next state; outputs are decoded from the next state so they flip on the same edge
  always_comb begin
    state_d    = state_q;
    to_d       = to_q;
    wd_d       = wd_q;
    halt_err_d = halt_err_q;

    if (pclk0) begin
      case (state_q)
        ST_CPU_OWN: begin
          if (bus.clr_req) begin
            state_d = ST_CLR_OWN;
          end else if (bus.dma_req) begin
            state_d = ST_HALT_REQ;
            to_d    = '0;
          end
        end
        ST_HALT_REQ: begin
          if (bus.clr_req) begin
            state_d = ST_CLR_OWN;
          end else if (!bus.dma_req) begin
            state_d = ST_RELEASE;
          end else if (bus.cpu_halted) begin
            state_d = ST_DMA_OWN;
            wd_d    = '0;
          end else begin
            to_d = to_inc;
            if (to_inc == TO_W'(HALT_TIMEOUT)) begin
              state_d    = ST_DMA_OWN;
              wd_d       = '0;
              halt_err_d = 1'b1;
            end
          end
        end
        ST_DMA_OWN: begin
          wd_d = wd_inc;
          if (wd_expire) halt_err_d = 1'b1;
          if (bus.dma_done || !bus.dma_req || wd_expire) state_d = ST_RELEASE;
        end
        ST_RELEASE: state_d = ST_CPU_OWN;
        ST_CLR_OWN: begin
          if (!bus.clr_req) state_d = ST_CPU_OWN;
        end
        default: state_d = ST_CPU_OWN;
      endcase
    end

    cpu_grant_d  = (state_d == ST_CPU_OWN);
    dma_grant_d  = (state_d == ST_DMA_OWN);
    clr_grant_d  = (state_d == ST_CLR_OWN);
    cpu_halt_b_d = !((state_d == ST_HALT_REQ) || (state_d == ST_DMA_OWN) ||
                     (state_d == ST_RELEASE));
    case (state_d)
      ST_CPU_OWN: owner_d = OWN_CPU;
      ST_DMA_OWN: owner_d = OWN_DMA;
      ST_CLR_OWN: owner_d = OWN_CLR;
      default:    owner_d = OWN_TRN;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= ST_CPU_OWN;
      to_q         <= '0;
      wd_q         <= '0;
      halt_err_q   <= 1'b0;
      cpu_grant_q  <= 1'b1;
      dma_grant_q  <= 1'b0;
      clr_grant_q  <= 1'b0;
      cpu_halt_b_q <= 1'b1;
      owner_q      <= OWN_CPU;
    end else begin
      state_q      <= state_d;
      to_q         <= to_d;
      wd_q         <= wd_d;
      halt_err_q   <= halt_err_d;
      cpu_grant_q  <= cpu_grant_d;
      dma_grant_q  <= dma_grant_d;
      clr_grant_q  <= clr_grant_d;
      cpu_halt_b_q <= cpu_halt_b_d;
      owner_q      <= owner_d;
    end
  end

  assign bus.cpu_grant  = cpu_grant_q;
  assign bus.dma_grant  = dma_grant_q;
  assign bus.clr_grant  = clr_grant_q;
  assign bus.cpu_halt_b = cpu_halt_b_q;
  assign bus.owner      = owner_q;
  assign bus.halt_err   = halt_err_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_cnt_q, stat_cnt_d;
  logic [15:0] dma_slots_q, dma_slots_d;
  logic        slot_counted;

  // Slots the CPU loses to DMA: halt wait, DMA ownership and the release gap
  assign slot_counted = pclk0 && ((state_q == ST_HALT_REQ) || (state_q == ST_DMA_OWN) ||
                                  (state_q == ST_RELEASE));

  always_comb begin
    stat_cnt_d  = stat_cnt_q;
    dma_slots_d = dma_slots_q;
    if (pclk0 && frame_start) begin
      dma_slots_d = stat_cnt_q;
      stat_cnt_d  = slot_counted ? 16'd1 : 16'd0;
    end else if (slot_counted && (stat_cnt_q != 16'hFFFF)) begin
      stat_cnt_d = stat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      stat_cnt_q  <= '0;
      dma_slots_q <= '0;
    end else begin
      stat_cnt_q  <= stat_cnt_d;
      dma_slots_q <= dma_slots_d;
    end
  end

  assign dma_slots = dma_slots_q;
`endif

endmodule

// File: doc/bus_arbiter_7800.md
Name: bus_arbiter_7800

Overview:
- Sequences ownership of the shared 7800 system bus (AB/RW/DB to RAM0/RAM1, cart, BIOS, TIA, RIOT) between three requesters:
  - memory-clear engine during loading;
  - MARIA DMA;
  - the 6502 (Sally), which is the default owner.
- Performs the halt handshake with the CPU wrapper: assert halt, wait for the bus-release acknowledge, grant DMA, then release.
- Drives the top-level AB/RW mux selects and a halt signal in place of ad-hoc combinational muxing.

Parameters:
- HALT_TIMEOUT, 7, number of pclk0 slots to wait for cpu_halted before flagging error and granting anyway.
- DMA_MAX, 1023, watchdog limit on consecutive pclk0 slots in DMA_OWN; forces release when reached.
- CNT_W, 10, width of the DMA watchdog counter; must satisfy 2^CNT_W > DMA_MAX.

Ports:
- clk_sys in 1 system clock; all logic rising-edge.
- reset_n in 1 synchronous reset, active-low.
- pclk0 in 1 bus-phase enable; the FSM advances only on clk_sys edges with pclk0=1.
- clr_req in 1 memory-clear engine request (level).
- clr_grant out 1 clear engine owns bus.
- dma_req in 1 MARIA DMA request (level; held until dma_done).
- dma_done in 1 single-slot pulse from MARIA: DMA list finished.
- dma_grant out 1 MARIA owns bus; top muxes maria_AB_out, forces RW=1.
- cpu_halt_b out 1 to CPU wrapper halt_b; 0 requests halt.
- cpu_halted in 1 CPU wrapper is_halted acknowledge.
- cpu_grant out 1 CPU owns bus.
- owner out 2 00=CPU, 01=DMA, 10=CLR, 11=transition (no driver; RW forced 1).
- halt_err out 1 sticky: halt timeout or DMA watchdog fired; cleared only by reset.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge, regardless of pclk0):
  - state=CPU_OWN, cpu_grant=1, cpu_halt_b=1, dma_grant=0, clr_grant=0, owner=00, halt_err=0, all counters 0.
- States: CPU_OWN, HALT_REQ, DMA_OWN, RELEASE, CLR_OWN.
- Outputs are registered and change only on the same edge as the state.
- CPU_OWN:
  - clr_req=1 → CLR_OWN directly; clear runs only while the CPU is held in reset/loading, so no halt handshake.
  - Else dma_req=1 → HALT_REQ: cpu_halt_b=0, cpu_grant=0, owner=11, timeout counter cleared.
- HALT_REQ:
  - cpu_halted=1 → DMA_OWN: dma_grant=1, owner=01, watchdog cleared.
  - Counter reaching HALT_TIMEOUT → DMA_OWN with halt_err=1.
  - dma_req dropping before grant → RELEASE.
  - clr_req has priority over every other condition in this state → CLR_OWN.
- DMA_OWN:
  - Watchdog increments each slot.
  - dma_done=1, or dma_req=0, or watchdog==DMA_MAX → RELEASE: dma_grant=0, owner=11. Watchdog expiry also sets halt_err.
  - cpu_halt_b stays 0.
- RELEASE: one slot, then CPU_OWN with cpu_halt_b=1, cpu_grant=1, owner=00.
  - A dma_req still high in CPU_OWN after release restarts the handshake on the next slot.
  - This guarantees at least one CPU slot between DMA bursts.
- CLR_OWN:
  - clr_grant=1, owner=10, cpu_halt_b=1; the CPU is in reset, so the halt is ignored.
  - clr_req=0 → CPU_OWN.
  - dma_req is ignored.
- Simultaneous dma_done and clr_req in DMA_OWN → RELEASE, then CPU_OWN, then CLR_OWN.
- Exactly one of cpu_grant/dma_grant/clr_grant is 1, or none when owner=11; never two.
- Latency, dma_req to dma_grant: 1 slot into HALT_REQ plus the number of slots until cpu_halted.
  - Minimum 2 pclk0 slots when cpu_halted rises on the first HALT_REQ slot.
- Counters saturate and never wrap.

Optional Feature:
- ARB_STATS_EN.
- When defined: adds input frame_start (1 bit, pulse) and output dma_slots (16 bits).
  - A counter counts pclk0 slots spent in HALT_REQ+DMA_OWN+RELEASE and saturates at 16'hFFFF.
  - On frame_start the running count is latched into dma_slots and the counter reloads to 0, or to 1 if that slot is itself counted.
  - Reset clears both.
- When undefined: neither port exists and no counter logic is present.

Test Plan:
- Reset with reset_n=0 for 3 clk_sys edges, pclk0 toggling → owner=00, cpu_halt_b=1, cpu_grant=1, halt_err=0 on the first edge.
- dma_req=1; cpu_halted rises 2 slots after cpu_halt_b falls; dma_done after 40 slots → dma_grant high for exactly 40 slots, then one owner=11 slot, then owner=00, cpu_halt_b=1.
- dma_req=1 with cpu_halted held 0 → dma_grant=1 and halt_err=1 after 7 HALT_REQ slots.
- DMA_MAX=15, dma_req held, dma_done never asserted → release after 15 DMA slots, halt_err=1, regrant begins 2 slots later, at least 1 slot with cpu_grant=1 between.
- clr_req=1 during HALT_REQ → next slot owner=10, clr_grant=1, cpu_halt_b=1; clr_req=0 → owner=00.
- With ARB_STATS_EN: two 40-slot bursts with cpu_halted immediate, then frame_start → dma_slots=84 (2×(1+40+1)).
